// File: rtl/trigger_surround_cache.sv
// ---------------------------------------------------------------------------
// trigger_surround_cache
//
// Captures a window of 8-bit samples from an internal deterministic sample
// generator around a threshold trigger. The samples go into a BUF_LEN-deep
// ring buffer. After the trigger, the block freezes the window and delivers
// it to the host, oldest sample first. Each host request returns one sample.
//
// Ports
//   clk       in   1   single clock, rising edge
//   reset     in   1   synchronous, active-high; returns the block to IDLE
//   start     in   1   begins a capture (sampled only in IDLE)
//   req       in   1   host read request; each rising edge asks for one sample
//   sbf       in   1   host buffer full; holds a pending request back
//   adc_data  out  8   generator sample during capture, delivered sample during readout
//   trd       out  1   trigger detected (level)
//   cd        out  1   cache done: window frozen and readable (level)
//   rdy       out  1   one-cycle pulse: adc_data holds a newly delivered sample
//   trigtm    out  32  free-running cycle count latched at the trigger
//   sd        out  1   one-cycle pulse: the last window sample has been delivered
// ---------------------------------------------------------------------------
module trigger_surround_cache #(
    parameter int         BUF_LEN = 32,
    parameter int         PRE     = 16,
    parameter logic [7:0] THRESH  = 8'd200,
    parameter logic [7:0] STEP    = 8'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        req,
    input  logic        sbf,
    output logic [7:0]  adc_data,
    output logic        trd,
    output logic        cd,
    output logic        rdy,
    output logic [31:0] trigtm,
    output logic        sd
);

    localparam int AW = $clog2(BUF_LEN);

    // Terminal values of the phase and readout counters.
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(BUF_LEN - PRE - 2);
    localparam logic [AW-1:0] RD_LAST   = AW'(BUF_LEN - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PRE_FILL  = 4'd1,
        WAIT_TRIG = 4'd2,
        POST      = 4'd3,
        READY     = 4'd4,
        XFER      = 4'd5
    } state_t;

    state_t        state_q;
    logic [31:0]   cycle_q;
    logic [31:0]   trigtm_q;
    logic [7:0]    gen_q;
    logic [7:0]    adc_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] phase_q;     // samples written in PRE_FILL / POST
    logic [AW-1:0] rd_cnt_q;    // samples delivered so far
    logic          req_q;       // req from the previous cycle, for edge detection
    logic          pend_q;      // one outstanding host request
    logic          last_q;      // final window sample has just been delivered
    logic          trd_q;
    logic          cd_q;
    logic          rdy_q;
    logic          sd_q;

    logic [7:0]    mem [BUF_LEN];

    logic          capture;
    logic          req_rise;
    logic          serve;
    logic [7:0]    gen_d;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_d;

    assign capture  = (state_q == PRE_FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
    assign req_rise = req & ~req_q;
    // cd_q is set only once the read pointer has been loaded. Requests wait
    // for that load.
    assign serve    = cd_q & pend_q & ~sbf & ~last_q;
    assign gen_d    = gen_q + STEP;
    assign wr_ptr_d = wr_ptr_q + 1'b1;
    assign rd_ptr_d = rd_ptr_q + 1'b1;

    // NOTE: the sample memory has no reset. Its contents are always rewritten
    // by a capture before they are read. Leaving it unreset keeps it mappable
    // onto RAM.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr_q] <= gen_q;
        end
    end

    // NOTE: all state updates use non-blocking assignments. Every branch
    // therefore sees the pre-edge values of gen_q, wr_ptr_q and the other
    // state registers, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cycle_q  <= '0;
            trigtm_q <= '0;
            gen_q    <= '0;
            adc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            phase_q  <= '0;
            rd_cnt_q <= '0;
            req_q    <= 1'b0;
            pend_q   <= 1'b0;
            last_q   <= 1'b0;
            trd_q    <= 1'b0;
            cd_q     <= 1'b0;
            rdy_q    <= 1'b0;
            sd_q     <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            req_q   <= req;
            rdy_q   <= 1'b0;
            sd_q    <= 1'b0;

            // The ring buffer is written by the separate memory block above.
            // This block only advances the pointer and the generator.
            if (capture) begin
                adc_q    <= gen_q;
                wr_ptr_q <= wr_ptr_d;
                gen_q    <= gen_d;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        gen_q    <= '0;
                        wr_ptr_q <= '0;
                        phase_q  <= '0;
                        state_q  <= PRE_FILL;
                    end
                end

                PRE_FILL: begin
                    if (phase_q == PRE_LAST) begin
                        phase_q <= '0;
                        state_q <= WAIT_TRIG;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end

                WAIT_TRIG: begin
                    // The sample being written is the trigger candidate. It
                    // becomes the first post-trigger sample.
                    if (gen_q >= THRESH) begin
                        trd_q    <= 1'b1;
                        trigtm_q <= cycle_q;
                        phase_q  <= '0;
                        state_q  <= POST;
                    end
                end

                POST: begin
                    if (phase_q == POST_LAST) begin
                        state_q <= READY;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end

                READY, XFER: begin
                    if (!cd_q) begin
                        // First frozen cycle. The write pointer already points
                        // at the oldest sample in the ring.
                        cd_q     <= 1'b1;
                        rd_ptr_q <= wr_ptr_q;
                        rd_cnt_q <= '0;
                        last_q   <= 1'b0;
                        pend_q   <= req_rise;
                    end else if (last_q) begin
                        sd_q    <= 1'b1;
                        trd_q   <= 1'b0;
                        cd_q    <= 1'b0;
                        last_q  <= 1'b0;
                        pend_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (serve) begin
                        adc_q    <= mem[rd_ptr_q];
                        rd_ptr_q <= rd_ptr_d;
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        rdy_q    <= 1'b1;
                        pend_q   <= 1'b0;
                        last_q   <= (rd_cnt_q == RD_LAST);
                        state_q  <= XFER;
                    end else if (req_rise) begin
                        // A second edge while one request is pending sets
                        // the same flag. The extra request is lost.
                        pend_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign adc_data = adc_q;
    assign trd      = trd_q;
    assign cd       = cd_q;
    assign rdy      = rdy_q;
    assign trigtm   = trigtm_q;
    assign sd       = sd_q;

endmodule

// File: tb/tb_trigger_surround_cache.sv
// ---------------------------------------------------------------------------
// tb_trigger_surround_cache
//
// Self-checking bench for trigger_surround_cache. It covers:
//   - the directed capture, checked sample by sample;
//   - a table-driven readout of the frozen window, with some entries held
//     back by sbf;
//   - reset in the middle of a capture;
//   - randomized req/sbf readouts, compared against a window model built
//     from the sampling rules.
// ---------------------------------------------------------------------------
module tb_trigger_surround_cache;

    localparam int BUF_LEN = 32;
    localparam int PRE     = 16;
    localparam int THRESH  = 200;
    localparam int STEP    = 7;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        req   = 1'b0;
    logic        sbf   = 1'b0;
    logic [7:0]  adc_data;
    logic        trd;
    logic        cd;
    logic        rdy;
    logic [31:0] trigtm;
    logic        sd;

    int          checks = 0;
    int          errors = 0;

    // Bench copy of the free-running cycle counter.
    logic [31:0] m_cnt = '0;

    // Pulse monitor. It samples just after each rising edge.
    int          rdy_cnt = 0;
    int          sd_cnt  = 0;
    logic [31:0] rdy_time = '0;
    logic [31:0] sd_time  = '0;
    logic [7:0]  got_q[$];

    trigger_surround_cache dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .req      (req),
        .sbf      (sbf),
        .adc_data (adc_data),
        .trd      (trd),
        .cd       (cd),
        .rdy      (rdy),
        .trigtm   (trigtm),
        .sd       (sd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) m_cnt <= '0;
        else       m_cnt <= m_cnt + 32'd1;
    end

    always @(posedge clk) begin
        #1;
        if (rdy === 1'b1) begin
            rdy_cnt++;
            rdy_time = m_cnt;
            got_q.push_back(adc_data);
        end
        if (sd === 1'b1) begin
            sd_cnt++;
            sd_time = m_cnt;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Sample k of a capture: the generator starts at 0 and steps by STEP mod 256.
    function automatic logic [7:0] sample(input int k);
        return 8'((k * STEP) % 256);
    endfunction

    // Index of the first sample at or after PRE that reaches the threshold.
    function automatic int trig_index();
        for (int k = PRE; k < PRE + 512; k++) begin
            if (int'(sample(k)) >= THRESH) return k;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " adc_data"}, 32'(adc_data), 32'd0);
        check({tag, " trd"},      32'(trd),      32'd0);
        check({tag, " cd"},       32'(cd),       32'd0);
        check({tag, " rdy"},      32'(rdy),      32'd0);
        check({tag, " sd"},       32'(sd),       32'd0);
        check({tag, " trigtm"},   trigtm,        32'd0);
    endtask

    typedef struct {
        int         sbf_hold;   // cycles sbf stays high after the req edge
        logic [7:0] exp_data;   // sample the request must return
    } vec_t;

    vec_t        vecs[BUF_LEN];
    logic [7:0]  win_lit[BUF_LEN];
    logic [7:0]  exp_q[$];
    logic [31:0] start_cnt;
    logic [31:0] saved_trigtm;
    int          tk;
    int          base;
    int          n;
    int          sd_base;

    initial begin
        // Window after the directed capture: samples 13..44 of 0,7,14,...
        win_lit = '{8'd91,  8'd98,  8'd105, 8'd112, 8'd119, 8'd126, 8'd133, 8'd140,
                    8'd147, 8'd154, 8'd161, 8'd168, 8'd175, 8'd182, 8'd189, 8'd196,
                    8'd203, 8'd210, 8'd217, 8'd224, 8'd231, 8'd238, 8'd245, 8'd252,
                    8'd3,   8'd10,  8'd17,  8'd24,  8'd31,  8'd38,  8'd45,  8'd52};
        for (int i = 0; i < BUF_LEN; i++) begin
            vecs[i].sbf_hold = (i == 0 || i == 3 || i == 17 || i == 31) ? 5 : 0;
            vecs[i].exp_data = win_lit[i];
        end
        tk = trig_index();

        // ---- reset state ----
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // ---- req toggles in IDLE are ignored ----
        repeat (4) begin
            req = 1'b1; tick();
            req = 1'b0; tick();
        end
        check("idle req no rdy", 32'(rdy_cnt), 32'd0);

        // ---- directed capture, sample by sample ----
        start_cnt = m_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < tk + (BUF_LEN - PRE); k++) begin
            tick();
            req = (k % 3 == 0);   // ignored during capture
            check($sformatf("cap sample %0d", k), 32'(adc_data), 32'(sample(k)));
            check($sformatf("cap trd %0d", k), 32'(trd), 32'(k >= tk));
            if (k == tk) check("trigtm", trigtm, start_cnt + 32'(tk + 1));
        end
        req = 1'b0;
        check("trigger index", 32'(tk), 32'd29);
        check("cd before freeze", 32'(cd), 32'd0);
        tick();
        check("cd after freeze", 32'(cd), 32'd1);
        check("capture req no rdy", 32'(rdy_cnt), 32'd0);
        saved_trigtm = trigtm;

        // ---- start is ignored once frozen ----
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        tick();
        check("ready start cd", 32'(cd), 32'd1);
        check("ready start trd", 32'(trd), 32'd1);
        check("ready hold adc", 32'(adc_data), 32'd52);
        check("ready start trigtm", trigtm, saved_trigtm);

        // ---- table-driven readout ----
        base = rdy_cnt;
        for (int i = 0; i < BUF_LEN; i++) begin
            req = 1'b1;
            if (vecs[i].sbf_hold > 0) begin
                sbf = 1'b1;
                repeat (vecs[i].sbf_hold) tick();
                check($sformatf("sbf hold no rdy %0d", i), 32'(rdy_cnt), 32'(base + i));
                sbf = 1'b0;
            end
            n = 0;
            while (rdy_cnt == base + i && n < 8) begin
                tick();
                n++;
            end
            check($sformatf("rd rdy count %0d", i), 32'(rdy_cnt), 32'(base + i + 1));
            check($sformatf("rd latency %0d", i), 32'(n <= 2), 32'd1);
            check($sformatf("rd data %0d", i), 32'(adc_data), 32'(vecs[i].exp_data));
            repeat (3) tick();
            req = 1'b0;
            repeat (5) tick();
        end
        check("total rdy", 32'(rdy_cnt), 32'(base + BUF_LEN));
        check("sd count", 32'(sd_cnt), 32'd1);
        check("sd follows last rdy", sd_time, rdy_time + 32'd1);
        check("done trd", 32'(trd), 32'd0);
        check("done cd", 32'(cd), 32'd0);
        check("done adc hold", 32'(adc_data), 32'd52);
        check("done trigtm hold", trigtm, saved_trigtm);

        // ---- req toggles in IDLE after readout produce nothing ----
        base = rdy_cnt;
        repeat (3) begin
            req = 1'b1; tick();
            req = 1'b0; tick();
        end
        check("post-done req no rdy", 32'(rdy_cnt), 32'(base));

        // ---- reset in the middle of POST ----
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (35) tick();
        check("mid-post trd set", 32'(trd), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid-post reset");

        // ---- randomized readouts against the window model ----
        for (int it = 0; it < 4; it++) begin
            got_q.delete();
            exp_q.delete();
            for (int k = 0; k < tk + (BUF_LEN - PRE); k++) begin
                exp_q.push_back(sample(k));
                if (exp_q.size() > BUF_LEN) void'(exp_q.pop_front());
            end
            sd_base = sd_cnt;

            start_cnt = m_cnt;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (cd !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            check($sformatf("rnd%0d cd", it), 32'(cd), 32'd1);
            check($sformatf("rnd%0d trd", it), 32'(trd), 32'd1);
            check($sformatf("rnd%0d trigtm", it), trigtm, start_cnt + 32'(tk + 1));

            n = 0;
            while (sd_cnt == sd_base && n < 3000) begin
                req = 1'($urandom_range(0, 1));
                sbf = ($urandom_range(0, 3) == 0);
                tick();
                n++;
            end
            req = 1'b0;
            sbf = 1'b0;
            check($sformatf("rnd%0d sd seen", it), 32'(sd_cnt), 32'(sd_base + 1));
            check($sformatf("rnd%0d sample count", it), 32'(got_q.size()), 32'(BUF_LEN));
            for (int j = 0; j < BUF_LEN; j++) begin
                check($sformatf("rnd%0d data %0d", it, j),
                      (j < got_q.size()) ? 32'(got_q[j]) : 32'hFFFF_FFFF,
                      32'(exp_q[j]));
            end
            check($sformatf("rnd%0d cd clear", it), 32'(cd), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
